// File: rtl/capture_buffer_if.sv
// Capture buffer signal bundle: sample stream, capture control and UART byte handshake.
// master = controller/sampler/UART environment side, slave = the capture buffer itself.
interface capture_buffer_if #(
  parameter int SAMPLE_WIDTH = 8
);
  logic                    arm;
  logic                    run;
  logic [SAMPLE_WIDTH-1:0] data_in;
  logic                    valid_in;
  logic [15:0]             read_count;
  logic [15:0]             delay_count;
  logic                    tx_busy;
  logic [SAMPLE_WIDTH-1:0] data_out;
  logic                    data_ready;
  logic                    busy;
  logic                    done;

  modport master (
    output arm, run, data_in, valid_in, read_count, delay_count, tx_busy,
    input  data_out, data_ready, busy, done
  );

  modport slave (
    input  arm, run, data_in, valid_in, read_count, delay_count, tx_busy,
    output data_out, data_ready, busy, done
  );
endinterface

// File: rtl/capture_buffer.sv
// Circular pre/post-trigger sample capture, read out newest-first one byte per UART handshake.
// Samples are written the cycle they arrive; each byte waits in SEND until tx_busy is low.
module capture_buffer #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic             clock,
  input  logic             reset,
  capture_buffer_if.slave  cb
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0]         REM_ONE = 1;

  typedef enum logic [2:0] {
    IDLE, PRE, POST, FETCH, SEND, WAIT_HI, WAIT_LO
  } state_t;

  state_t                  state, state_nxt;
  logic                    arm_q;
  logic                    arm_rise;
  logic [ADDR_WIDTH-1:0]   wr_ptr, wr_ptr_nxt, rd_ptr;
  logic [15:0]             post_cnt, delay_lat;
  logic [CW-1:0]           read_rem, read_clamp;
  logic [SAMPLE_WIDTH-1:0] mem [DEPTH];
  logic [SAMPLE_WIDTH-1:0] data_out_q;
  logic                    data_ready_q, done_q;

  logic mem_we, mem_re, ready_set, done_set, post_inc, rem_dec, load_rd;
  logic post_last;

  assign arm_rise   = cb.arm & ~arm_q;
  assign read_clamp = ({1'b0, cb.read_count} > 17'(DEPTH)) ? CW'(DEPTH) : CW'(cb.read_count);
  // >= rather than == so a zero delay with a deferred trigger still stops on the first sample
  assign post_last  = ({1'b0, post_cnt} + 17'd1) >= {1'b0, delay_lat};
  assign wr_ptr_nxt = mem_we ? wr_ptr + PTR_ONE : wr_ptr;

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    ready_set = 1'b0;
    done_set  = 1'b0;
    post_inc  = 1'b0;
    rem_dec   = 1'b0;
    load_rd   = 1'b0;
    if (arm_rise) begin
      state_nxt = PRE;
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        PRE: begin
          mem_we = cb.valid_in;
          if (cb.run) begin
            if (cb.valid_in && delay_lat == 16'd0) begin
              state_nxt = FETCH;
              load_rd   = 1'b1;
            end else begin
              state_nxt = POST;
            end
          end
        end
        POST: begin
          if (cb.valid_in) begin
            mem_we   = 1'b1;
            post_inc = 1'b1;
            if (post_last) begin
              state_nxt = FETCH;
              load_rd   = 1'b1;
            end
          end
        end
        FETCH: begin
          if (read_rem == '0) begin
            done_set  = 1'b1;
            state_nxt = IDLE;
          end else begin
            mem_re    = 1'b1;
            state_nxt = SEND;
          end
        end
        SEND: begin
          if (!cb.tx_busy) begin
            ready_set = 1'b1;
            state_nxt = WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (cb.tx_busy) state_nxt = WAIT_LO;
        end
        WAIT_LO: begin
          if (!cb.tx_busy) begin
            rem_dec = 1'b1;
            if (read_rem == REM_ONE) begin
              done_set  = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = FETCH;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we && !reset) mem[wr_ptr] <= cb.data_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      arm_q        <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      post_cnt     <= '0;
      delay_lat    <= '0;
      read_rem     <= '0;
      data_out_q   <= '0;
      data_ready_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_nxt;
      arm_q        <= cb.arm;
      data_ready_q <= ready_set;
      done_q       <= done_set;
      if (arm_rise) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        post_cnt  <= '0;
        delay_lat <= cb.delay_count;
        read_rem  <= read_clamp;
      end else begin
        wr_ptr <= wr_ptr_nxt;
        if (post_inc) post_cnt <= post_cnt + 16'd1;
        // newest sample sits one below the next write slot
        if (load_rd)     rd_ptr <= wr_ptr_nxt - PTR_ONE;
        else if (mem_re) rd_ptr <= rd_ptr - PTR_ONE;
        if (rem_dec) read_rem <= read_rem - REM_ONE;
        if (mem_re)  data_out_q <= mem[rd_ptr];
      end
    end
  end

  assign cb.data_out   = data_out_q;
  assign cb.data_ready = data_ready_q;
  assign cb.done       = done_q;
  assign cb.busy       = (state != IDLE);

endmodule

// File: tb/tb_capture_buffer.sv
// Directed bench for capture_buffer: a queue model predicts the newest-first byte stream,
// a per-cycle monitor checks every data_ready/done against it, plus literal expectations.
module tb_capture_buffer;
  localparam int SW = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  capture_buffer_if #(.SAMPLE_WIDTH(SW)) cb ();
  capture_buffer #(.SAMPLE_WIDTH(SW), .ADDR_WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .cb    (cb)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0] fed[$];
  logic [7:0] exp_arr[$];
  logic [7:0] got_q[$];
  int epoch = 0;
  int hold_cycles = 3;
  int stall_req = 0;
  int done_cnt = 0;
  int dr_cnt = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: the stored history is the first n_stored valid samples since arm;
  // readout is its newest min(rc, 256) entries, newest first.
  function automatic void build_exp(input int n_stored, input int rc);
    int n;
    exp_arr.delete();
    n = (rc > 256) ? 256 : rc;
    if (n > n_stored) n = n_stored;
    for (int i = 0; i < n; i++) exp_arr.push_back(fed[n_stored - 1 - i]);
  endfunction

  task automatic arm_cap(input int rc, input int dc);
    epoch++;
    fed.delete();
    exp_arr.delete();
    cb.read_count  = 16'(rc);
    cb.delay_count = 16'(dc);
    cb.arm = 1'b1;
    @(posedge clock); #1;
    cb.arm = 1'b0;
  endtask

  task automatic feed(input logic [7:0] d, input logic r);
    cb.data_in  = d;
    cb.valid_in = 1'b1;
    cb.run      = r;
    fed.push_back(d);
    @(posedge clock); #1;
    cb.valid_in = 1'b0;
    cb.run      = 1'b0;
  endtask

  task automatic idle_cycle(input logic r);
    cb.valid_in = 1'b0;
    cb.run      = r;
    @(posedge clock); #1;
    cb.run = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int start = done_cnt;
    int i = 0;
    while (done_cnt == start && i < budget) begin
      @(negedge clock);
      i++;
    end
    check({name, "_done_pulse"}, done_cnt - start, 1);
    @(negedge clock);
    check({name, "_busy_after_done"}, int'(cb.busy), 0);
    repeat (3) @(negedge clock);
    check({name, "_single_done"}, done_cnt - start, 1);
    @(posedge clock); #1;
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int i = 0;
    while (got_q.size() < n && i < budget) begin
      @(negedge clock);
      i++;
    end
    check("bytes_before_abort", (got_q.size() >= n) ? n : got_q.size(), n);
    @(posedge clock); #1;
  endtask

  // Per-cycle monitor against the model.
  initial begin : compare
    int seen_epoch = 0;
    int exp_idx = 0;
    logic [7:0] held = 8'h00;
    logic hold_on = 1'b0;
    logic hold_seen_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (epoch != seen_epoch) begin
        seen_epoch = epoch;
        exp_idx = 0;
        got_q.delete();
        hold_on = 1'b0;
      end
      if (reset) begin
        hold_on = 1'b0;
      end else begin
        if (cb.data_ready) begin
          dr_cnt++;
          check("no_ready_while_tx_busy", int'(cb.tx_busy), 0);
          check("ready_within_expected", int'(exp_idx < exp_arr.size()), 1);
          if (exp_idx < exp_arr.size()) begin
            check("byte", int'(cb.data_out), int'(exp_arr[exp_idx]));
            exp_idx++;
          end
          got_q.push_back(cb.data_out);
          held = cb.data_out;
          hold_on = 1'b1;
          hold_seen_busy = 1'b0;
        end else if (hold_on) begin
          if (cb.tx_busy) begin
            hold_seen_busy = 1'b1;
            check("data_out_hold", int'(cb.data_out), int'(held));
          end else if (hold_seen_busy) begin
            hold_on = 1'b0;
          end
        end
        if (cb.done) begin
          done_cnt++;
          check("done_after_last_byte", exp_idx, exp_arr.size());
        end
      end
    end
  end

  // UART stand-in: goes busy after each data_ready, or on a stall request.
  initial begin : uart
    int ack = 0;
    int n = 0;
    cb.tx_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (cb.data_ready || stall_req != ack) begin
        n = cb.data_ready ? hold_cycles : 30;
        ack = stall_req;
        @(posedge clock); #1;
        cb.tx_busy = 1'b1;
        repeat (n) @(posedge clock);
        #1;
        cb.tx_busy = 1'b0;
      end
    end
  end

  initial begin : main
    int d0;
    int r0;
    cb.arm = 1'b1;
    cb.run = 1'b0;
    cb.valid_in = 1'b0;
    cb.data_in = '0;
    cb.read_count = '0;
    cb.delay_count = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_data_out", int'(cb.data_out), 0);
    check("rst_data_ready", int'(cb.data_ready), 0);
    check("rst_busy_with_arm", int'(cb.busy), 0);
    check("rst_done", int'(cb.done), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    cb.arm = 1'b0;

    // run/valid in IDLE do nothing
    feed(8'hAA, 1'b1);
    feed(8'hAB, 1'b1);
    @(negedge clock);
    check("idle_run_ignored", int'(cb.busy), 0);
    @(posedge clock); #1;

    // basic: 1..10, trigger on 5, delay 5, read 4
    arm_cap(4, 5);
    feed(8'h01, 1'b0); feed(8'h02, 1'b0); feed(8'h03, 1'b0);
    idle_cycle(1'b0);
    feed(8'h04, 1'b0); feed(8'h05, 1'b1);
    idle_cycle(1'b0);
    for (int i = 6; i <= 10; i++) feed(8'(i), 1'b0);
    build_exp(10, 4);
    wait_done("basic", 400);
    check("basic_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check("basic_b0", int'(got_q[0]), 'h0A);
      check("basic_b1", int'(got_q[1]), 'h09);
      check("basic_b3", int'(got_q[3]), 'h07);
    end

    // zero delay: trigger on 0x33, read 1; trailing sample must not be stored
    arm_cap(1, 0);
    feed(8'h31, 1'b0); feed(8'h32, 1'b0); feed(8'h33, 1'b1);
    feed(8'h34, 1'b0);
    build_exp(3, 1);
    wait_done("zero_delay", 200);
    check("zero_delay_count", got_q.size(), 1);
    if (got_q.size() == 1) check("zero_delay_b0", int'(got_q[0]), 'h33);

    // read_count = 0
    r0 = dr_cnt;
    arm_cap(0, 3);
    feed(8'h40, 1'b0); feed(8'h41, 1'b1);
    feed(8'h42, 1'b0); feed(8'h43, 1'b0); feed(8'h44, 1'b0);
    build_exp(5, 0);
    wait_done("rc_zero", 100);
    check("rc_zero_no_ready", dr_cnt - r0, 0);

    // deferred trigger, 20-cycle UART hold, UART busy before readout
    hold_cycles = 20;
    stall_req++;
    arm_cap(3, 2);
    feed(8'h50, 1'b0); feed(8'h51, 1'b0);
    idle_cycle(1'b1);
    feed(8'h52, 1'b1); feed(8'h53, 1'b0);
    build_exp(4, 3);
    wait_done("handshake", 600);
    check("handshake_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("handshake_b0", int'(got_q[0]), 'h53);
      check("handshake_b2", int'(got_q[2]), 'h51);
    end

    // arm during readout aborts and restarts
    hold_cycles = 6;
    arm_cap(3, 1);
    feed(8'h80, 1'b0); feed(8'h81, 1'b0); feed(8'h82, 1'b1); feed(8'h83, 1'b0);
    build_exp(4, 3);
    wait_bytes(1, 200);
    arm_cap(1, 0);
    feed(8'h90, 1'b1);
    build_exp(1, 1);
    wait_done("rearm", 300);
    check("rearm_count", got_q.size(), 1);
    if (got_q.size() == 1) check("rearm_b0", int'(got_q[0]), 'h90);

    // wrap: 300 samples, trigger at 290, delay 9, read 256; extras after capture ignored
    hold_cycles = 2;
    arm_cap(256, 9);
    for (int i = 0; i < 300; i++) feed(8'(i), i == 290);
    feed(8'hEE, 1'b0); feed(8'hEF, 1'b0);
    build_exp(300, 256);
    wait_done("wrap", 6000);
    check("wrap_count", got_q.size(), 256);
    if (got_q.size() == 256) begin
      check("wrap_first", int'(got_q[0]), 'h2B);
      check("wrap_last", int'(got_q[255]), 'h2C);
    end

    // reset after 2 of 4 bytes
    hold_cycles = 20;
    arm_cap(4, 1);
    for (int i = 'h60; i <= 'h65; i++) feed(8'(i), i == 'h65);
    feed(8'h66, 1'b0);
    build_exp(7, 4);
    wait_bytes(2, 300);
    reset = 1'b1;
    epoch++;
    exp_arr.delete();
    @(posedge clock);
    @(negedge clock);
    check("abort_data_out", int'(cb.data_out), 0);
    check("abort_data_ready", int'(cb.data_ready), 0);
    check("abort_busy", int'(cb.busy), 0);
    check("abort_done", int'(cb.done), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    d0 = done_cnt;
    r0 = dr_cnt;
    repeat (60) @(posedge clock);
    #1;
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_no_ready", dr_cnt - r0, 0);
    arm_cap(2, 0);
    feed(8'h70, 1'b0); feed(8'h71, 1'b1);
    build_exp(2, 2);
    wait_done("post_abort", 300);
    check("post_abort_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("post_abort_b0", int'(got_q[0]), 'h71);
      check("post_abort_b1", int'(got_q[1]), 'h70);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
